// File: rtl/issue_queue.sv
// Circular issue queue: multi-entry insert at the tail, up to ISSUE_PER_CYCLE head
// entries presented combinationally, partial consume, branch flush and a sticky protocol-error flag.
module issue_queue #(
    parameter int  DEPTHLOG2        = 4,
    parameter int  ISSUE_PER_CYCLE  = 4,
    parameter int  INSERT_PER_CYCLE = 2,
    parameter int  ISS_PC_LOG2      = $clog2(ISSUE_PER_CYCLE),
    parameter int  INS_PC_LOG2      = $clog2(INSERT_PER_CYCLE),
    parameter type iq_entry_t       = logic [31:0]
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    ins_enable,
    input  logic [INS_PC_LOG2-1:0]                  ins_count,
    input  iq_entry_t [INSERT_PER_CYCLE-1:0]        ins_entries,
    output logic                                    full,
    input  logic                                    ext_enable,
    input  logic [ISS_PC_LOG2-1:0]                  ext_consumed,
    output logic [ISSUE_PER_CYCLE-1:0]              ext_valid,
    output iq_entry_t [ISSUE_PER_CYCLE-1:0]         insns,
    output logic                                    empty,
    input  logic                                    branch_flush,
    output logic [DEPTHLOG2:0]                      occupancy,
    output logic                                    proto_err
);

    localparam int DEPTH = 1 << DEPTHLOG2;

    typedef logic [DEPTHLOG2-1:0] ptr_t;
    typedef logic [DEPTHLOG2:0]   cnt_t;

    localparam cnt_t DEPTH_C   = cnt_t'(DEPTH);
    localparam cnt_t INS_PER_C = cnt_t'(INSERT_PER_CYCLE);

    iq_entry_t mem_q [DEPTH];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t occ_q, occ_d;
    logic err_q, err_d;

    cnt_t push_req, pop_req, push_cnt, pop_cnt;
    logic push_ok, push_drop, over_consume;

    // Full is judged on pre-pop occupancy, so a same-cycle pop never frees room for a push.
    assign full      = (DEPTH_C - occ_q) < INS_PER_C;
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign proto_err = err_q;

    assign push_req     = cnt_t'(ins_count) + cnt_t'(1);
    assign pop_req      = cnt_t'(ext_consumed) + cnt_t'(1);
    assign push_ok      = ins_enable && !full;
    assign push_drop    = ins_enable && full;
    assign over_consume = ext_enable && (pop_req > occ_q);
    assign push_cnt     = push_ok ? push_req : '0;

    always_comb begin
        pop_cnt = '0;
        if (ext_enable) begin
            pop_cnt = over_consume ? occ_q : pop_req;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        if (branch_flush) begin
            // Flush discards any same-cycle traffic, including its protocol violations.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(pop_cnt);
            wr_ptr_d = wr_ptr_q + ptr_t'(push_cnt);
            occ_d    = occ_q + push_cnt - pop_cnt;
            err_d    = err_q | push_drop | over_consume;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    // Storage is left unreset; only the pointers define which slots hold live entries.
    always_ff @(posedge clock) begin
        if (!reset && !branch_flush && push_ok) begin
            for (int k = 0; k < INSERT_PER_CYCLE; k++) begin
                if (cnt_t'(k) < push_req) begin
                    mem_q[ptr_t'(wr_ptr_q + ptr_t'(k))] <= ins_entries[k];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ISSUE_PER_CYCLE; gi++) begin : g_head
            assign insns[gi]     = mem_q[ptr_t'(rd_ptr_q + ptr_t'(gi))];
            assign ext_valid[gi] = (occ_q > cnt_t'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: fill/drain, wrap, simultaneous push/pop,
// full boundary, flush and over-consume with hand-computed expectations.
module tb_issue_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        ins_enable;
    logic [0:0]  ins_count;
    logic [1:0][31:0] ins_entries;
    logic        full;
    logic        ext_enable;
    logic [1:0]  ext_consumed;
    logic [3:0]  ext_valid;
    logic [3:0][31:0] insns;
    logic        empty;
    logic        branch_flush;
    logic [4:0]  occupancy;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    issue_queue dut (
        .clock       (clock),
        .reset       (reset),
        .ins_enable  (ins_enable),
        .ins_count   (ins_count),
        .ins_entries (ins_entries),
        .full        (full),
        .ext_enable  (ext_enable),
        .ext_consumed(ext_consumed),
        .ext_valid   (ext_valid),
        .insns       (insns),
        .empty       (empty),
        .branch_flush(branch_flush),
        .occupancy   (occupancy),
        .proto_err   (proto_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [7:0] t);
        return {t, ~t, t ^ 8'h5A, 8'hC3};
    endfunction

    task automatic idle_inputs();
        ins_enable   = 1'b0;
        ins_count    = '0;
        ins_entries  = '0;
        ext_enable   = 1'b0;
        ext_consumed = '0;
        branch_flush = 1'b0;
        reset        = 1'b0;
    endtask

    // One clock of stimulus; counts are real counts (1..2 insert, 1..4 consume).
    task automatic drive(input logic ie, input int icnt, input logic [7:0] t0, input logic [7:0] t1,
                         input logic ee, input int ecnt, input logic fl);
        ins_enable     = ie;
        ins_count      = 1'(icnt - 1);
        ins_entries[0] = mk(t0);
        ins_entries[1] = mk(t1);
        ext_enable     = ee;
        ext_consumed   = 2'(ecnt - 1);
        branch_flush   = fl;
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (ext_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b exp=0000", ext_valid); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", proto_err); end
        $display("test_reset done occ=%0d empty=%b full=%b", occupancy, empty, full);
    endtask

    task automatic test_fill_drain();
        for (int c = 0; c < 8; c++) drive(1, 2, 8'(2*c), 8'(2*c+1), 0, 1, 0);
        n_cmp++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL fill_occ got=%0d exp=16", occupancy); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (ext_valid !== 4'b1111) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1111", c, ext_valid); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (insns[i] !== mk(8'(4*c+i))) begin
                    n_err++; $display("FAIL drain_insn[%0d][%0d] got=%h exp=%h", c, i, insns[i], mk(8'(4*c+i)));
                end
            end
            drive(0, 1, 0, 0, 1, 4, 0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", empty); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL drain_err got=%b exp=0", proto_err); end
        $display("test_fill_drain done occ=%0d", occupancy);
    endtask

    task automatic test_wrap();
        // Walk both pointers to 14: 14 in, 14 out.
        for (int c = 0; c < 7; c++) drive(1, 2, 8'h70, 8'h71, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 4, 0);
        drive(0, 1, 0, 0, 1, 4, 0);
        drive(0, 1, 0, 0, 1, 4, 0);
        drive(0, 1, 0, 0, 1, 2, 0);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_pre_empty got=%b exp=1", empty); end
        drive(1, 2, 8'h20, 8'h21, 0, 1, 0);
        drive(1, 2, 8'h22, 8'h23, 0, 1, 0);
        n_cmp++; if (ext_valid !== 4'b1111) begin n_err++; $display("FAIL wrap_valid got=%b exp=1111", ext_valid); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (insns[i] !== mk(8'(8'h20 + i))) begin
                n_err++; $display("FAIL wrap_insn[%0d] got=%h exp=%h", i, insns[i], mk(8'(8'h20 + i)));
            end
        end
        drive(0, 1, 0, 0, 1, 4, 0);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_post_empty got=%b exp=1", empty); end
        $display("test_wrap done occ=%0d", occupancy);
    endtask

    task automatic test_simul_push_pop();
        drive(1, 2, 8'h30, 8'h31, 0, 1, 0);
        drive(1, 1, 8'h32, 8'h00, 0, 1, 0);
        n_cmp++; if (occupancy !== 5'd3) begin n_err++; $display("FAIL simul_pre_occ got=%0d exp=3", occupancy); end
        drive(1, 2, 8'h33, 8'h34, 1, 3, 0);
        n_cmp++; if (occupancy !== 5'd2) begin n_err++; $display("FAIL simul_occ got=%0d exp=2", occupancy); end
        n_cmp++; if (ext_valid !== 4'b0011) begin n_err++; $display("FAIL simul_valid got=%b exp=0011", ext_valid); end
        n_cmp++; if (insns[0] !== mk(8'h33)) begin n_err++; $display("FAIL simul_insn0 got=%h exp=%h", insns[0], mk(8'h33)); end
        n_cmp++; if (insns[1] !== mk(8'h34)) begin n_err++; $display("FAIL simul_insn1 got=%h exp=%h", insns[1], mk(8'h34)); end
        drive(0, 1, 0, 0, 1, 2, 0);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty got=%b exp=1", empty); end
        $display("test_simul_push_pop done occ=%0d", occupancy);
    endtask

    task automatic test_full_boundary();
        for (int c = 0; c < 7; c++) drive(1, 2, 8'(8'h40 + 2*c), 8'(8'h41 + 2*c), 0, 1, 0);
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_at14 got=%b exp=0", full); end
        drive(1, 1, 8'h4E, 8'h00, 0, 1, 0);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_at15 got=%b exp=1", full); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL full_err_pre got=%b exp=0", proto_err); end
        drive(1, 1, 8'h99, 8'h00, 0, 1, 0);
        n_cmp++; if (occupancy !== 5'd15) begin n_err++; $display("FAIL full_drop_occ got=%0d exp=15", occupancy); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL full_drop_err got=%b exp=1", proto_err); end
        drive(1, 1, 8'h98, 8'h00, 1, 4, 0);
        n_cmp++; if (occupancy !== 5'd11) begin n_err++; $display("FAIL full_pop_occ got=%0d exp=11", occupancy); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_pop_full got=%b exp=0", full); end
        n_cmp++; if (insns[0] !== mk(8'h44)) begin n_err++; $display("FAIL full_pop_insn0 got=%h exp=%h", insns[0], mk(8'h44)); end
        // The sticky error must survive a flush.
        drive(0, 1, 0, 0, 0, 1, 1);
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL flush_plain_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL flush_keeps_err got=%b exp=1", proto_err); end
        $display("test_full_boundary done occ=%0d err=%b", occupancy, proto_err);
    endtask

    task automatic test_flush_traffic();
        do_reset();
        for (int c = 0; c < 4; c++) drive(1, 2, 8'(8'h50 + 2*c), 8'(8'h51 + 2*c), 0, 1, 0);
        drive(1, 1, 8'h58, 8'h00, 0, 1, 0);
        n_cmp++; if (occupancy !== 5'd9) begin n_err++; $display("FAIL flush_pre_occ got=%0d exp=9", occupancy); end
        drive(1, 2, 8'h5A, 8'h5B, 1, 1, 1);
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got=%b exp=1", empty); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL flush_err got=%b exp=0", proto_err); end
        drive(1, 2, 8'h60, 8'h61, 0, 1, 0);
        n_cmp++; if (insns[0] !== mk(8'h60)) begin n_err++; $display("FAIL flush_slot0 got=%h exp=%h", insns[0], mk(8'h60)); end
        n_cmp++; if (insns[1] !== mk(8'h61)) begin n_err++; $display("FAIL flush_slot1 got=%h exp=%h", insns[1], mk(8'h61)); end
        // Flush at full with a push that would otherwise be an illegal drop.
        for (int c = 0; c < 7; c++) drive(1, 2, 8'h62, 8'h63, 0, 1, 0);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL flushfull_pre got=%b exp=1", full); end
        drive(1, 2, 8'h64, 8'h65, 0, 1, 1);
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL flushfull_err got=%b exp=0", proto_err); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL flushfull_occ got=%0d exp=0", occupancy); end
        $display("test_flush_traffic done occ=%0d err=%b", occupancy, proto_err);
    endtask

    task automatic test_overconsume_reset();
        do_reset();
        drive(1, 2, 8'h80, 8'h81, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 4, 0);
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL over_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL over_err got=%b exp=1", proto_err); end
        for (int c = 0; c < 3; c++) drive(1, 2, 8'h82, 8'h83, 0, 1, 0);
        drive(1, 1, 8'h84, 8'h00, 0, 1, 0);
        n_cmp++; if (occupancy !== 5'd7) begin n_err++; $display("FAIL rst_pre_occ got=%0d exp=7", occupancy); end
        // Reset with concurrent push, pop and flush: reset wins.
        ins_enable     = 1'b1;
        ins_count      = 1'b1;
        ins_entries[0] = mk(8'h90);
        ins_entries[1] = mk(8'h91);
        ext_enable     = 1'b1;
        ext_consumed   = 2'd0;
        branch_flush   = 1'b1;
        reset          = 1'b1;
        @(posedge clock);
        #1;
        idle_inputs();
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", proto_err); end
        n_cmp++; if (ext_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid got=%b exp=0000", ext_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", empty); end
        $display("test_overconsume_reset done occ=%0d err=%b", occupancy, proto_err);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simul_push_pop();
        test_full_boundary();
        test_flush_traffic();
        test_overconsume_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameters: DEPTHLOG2, 4, queue depth is 2**DEPTHLOG2 entries.
REQ-002 Parameters: ISSUE_PER_CYCLE, 4, number of head entries presented to the issue stage.
REQ-003 Parameters: INSERT_PER_CYCLE, 2, maximum entries written per cycle.
REQ-004 Parameters: ISS_PC_LOG2, $clog2(ISSUE_PER_CYCLE), consume-count width; INS_PC_LOG2, $clog2(INSERT_PER_CYCLE), insert-count width.
REQ-005 Ports: clock  in  1  sole clock, rising edge.
REQ-006 Ports: reset  in  1  synchronous, active-high reset.
REQ-007 Ports: ins_enable  in  1  insert request this cycle.
REQ-008 Ports: ins_count  in  INS_PC_LOG2  number of entries to insert, minus 1.
REQ-009 Ports: ins_entries  in  iq_entry_t[INSERT_PER_CYCLE]  entries to insert; index 0 is oldest.
REQ-010 Ports: full  out  1  fewer than INSERT_PER_CYCLE free slots.
REQ-011 Ports: ext_enable  in  1  issue stage consumes this cycle.
REQ-012 Ports: ext_consumed  in  ISS_PC_LOG2  number of entries consumed, minus 1.
REQ-013 Ports: ext_valid  out  1[ISSUE_PER_CYCLE]  head entry i is occupied.
REQ-014 Ports: insns  out  iq_entry_t[ISSUE_PER_CYCLE]  head entries, index 0 is oldest.
REQ-015 Ports: empty  out  1  occupancy is zero.
REQ-016 Ports: branch_flush  in  1  discard all entries.
REQ-017 Ports: occupancy  out  DEPTHLOG2+1  current entry count.
REQ-018 Ports: proto_err  out  1  sticky flag for an illegal insert or consume.

Function
REQ-019 Storage: circular buffer of 2**DEPTHLOG2 iq_entry_t; rd_ptr and wr_ptr are DEPTHLOG2 bits and wrap modulo depth; occupancy is a DEPTHLOG2+1-bit register.
REQ-020 Head outputs: insns[i] = mem[(rd_ptr+i) mod depth] and ext_valid[i] = (occupancy > i), both combinational from registered state with zero-cycle latency; insns contents are don't-care where ext_valid is 0.
REQ-021 Status outputs: empty = (occupancy == 0) and full = (depth - occupancy < INSERT_PER_CYCLE), both combinational from registered state.
REQ-022 Pop: when ext_enable=1, pop = ext_consumed+1, clamped to occupancy; rd_ptr advances by pop at the clock edge.
REQ-023 Push: when ins_enable=1 and full=0, push = ins_count+1; ins_entries[k] is written to mem[(wr_ptr+k) mod depth] for k < push, and wr_ptr advances by push.
REQ-024 Push while full: when ins_enable=1 and full=0 is not satisfied, the push is dropped with no state change and proto_err is set.
REQ-025 Occupancy update: occupancy_next = occupancy + push - pop; simultaneous push and pop in one cycle are both honoured.
REQ-026 Full flag: full is evaluated on pre-pop occupancy, so space freed by a same-cycle pop is not usable until the next cycle.
REQ-027 Over-consume: ext_enable=1 with ext_consumed+1 > occupancy pops only occupancy entries and sets proto_err.
REQ-028 Flush: branch_flush=1 sets rd_ptr = wr_ptr = 0 and occupancy = 0 at the clock edge.
REQ-029 Flush priority: flush overrides any same-cycle push or pop, and the dropped push does not set proto_err.
REQ-030 Order: entries leave in exactly the order inserted, and no entry is duplicated or skipped across pointer wrap.
REQ-031 proto_err: stays set until reset; branch_flush does not clear it.

Reset
REQ-032 Reset values: reset=1 at a clock edge clears rd_ptr, wr_ptr, occupancy and proto_err, so empty=1, full=0, all ext_valid=0 and occupancy=0.
REQ-033 Reset priority: reset has priority over flush, push and pop.
REQ-034 Reset mid-operation: reset asserted mid-operation discards all contents in one cycle.
REQ-035 Memory array: contents are not reset.

Verification
REQ-036 Fill/drain: from reset, push 2 entries per cycle (tags 0..15) for 8 cycles -> occupancy=16, full=1. Then consume 4 per cycle -> insns tags 0..3, 4..7, 8..11, 12..15 in order, and empty=1 after 4 cycles.
REQ-037 Wrap: with rd_ptr=wr_ptr=14, push 2 then 2 -> entries are stored at slots 14, 15, 0, 1; insns[0..3] show them in order and ext_valid=1111.
REQ-038 Simultaneous push and pop: at occupancy=3, push 2 and consume 3 in the same cycle -> occupancy=2 and insns[0] is the first newly pushed entry.
REQ-039 Full boundary: at occupancy=15, full=1; a push of 1 is dropped, proto_err=1 and occupancy stays 15. The same attempt with a concurrent pop of 4 is also dropped, and occupancy becomes 11.
REQ-040 Flush with traffic: at occupancy=9, branch_flush with concurrent push 2 and pop 1 -> occupancy=0 and empty=1 next cycle, proto_err unchanged; a subsequent push lands at slot 0.
REQ-041 Over-consume and reset: at occupancy=2, ext_consumed=3 -> occupancy=0 and proto_err=1. Reset asserted at occupancy=7 -> next cycle occupancy=0, proto_err=0 and ext_valid=0000.
